instr_fetch_ctrl: RTL and testbench

//  Sequences the combinational instruction memory: drives imem_addr from an internal fetch PC,

---
 rtl/instr_fetch_ctrl.sv | 99 +++++++++
 tb/tb_instr_fetch_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: walks a fetch PC over a combinational instruction memory,
// buffers {instr, pc} in a small prefetch FIFO and hands them to decode via valid/ready.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [3:0]  fifo_count,
  output logic        fetch_err
);

  localparam int unsigned AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0]  DEPTH = 4'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

  state_t          state;
  logic [31:0]     pc_q;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [3:0]      count;
  logic            err_q;
  logic [31:0]     buf_instr [FIFO_DEPTH];
  logic [31:0]     buf_pc    [FIFO_DEPTH];

  logic            pop;
  logic            push;
  logic            misalign;

  assign misalign = redirect_valid & (redirect_pc[1:0] != 2'b00);
  assign pop      = (count != '0) & out_ready;
  assign push     = (state == RUN) & fetch_en & ~redirect_valid & ((count < DEPTH) | pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      pc_q   <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      err_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE:    if (fetch_en)  state <= RUN;
        RUN:     if (!fetch_en) state <= IDLE;
        default: ;
      endcase

      if (redirect_valid) begin
        // Redirect outranks push and pop: the head is dropped, never delivered.
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        if (misalign) begin
          state <= ERR;
          err_q <= 1'b1;
        end else if (state != ERR) begin
          pc_q <= redirect_pc;
        end
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
          pc_q   <= pc_q + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        unique case ({push, pop})
          2'b10:   count <= count + 4'd1;
          2'b01:   count <= count - 4'd1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[wr_ptr] <= imem_rd_instr;
      buf_pc[wr_ptr]    <= pc_q;
    end
  end

  assign imem_addr  = pc_q;
  assign out_valid  = (count != '0);
  assign out_instr  = out_valid ? buf_instr[rd_ptr] : '0;
  assign out_pc     = out_valid ? buf_pc[rd_ptr] : '0;
  assign fifo_count = count;
  assign fetch_err  = err_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a hashed instruction-memory model and
// a PC scoreboard queue popped whenever decode accepts the head.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en, redirect_valid, out_ready;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_rd_instr, out_instr, out_pc;
  logic        out_valid, fetch_err;
  logic [3:0]  fifo_count;

  logic        fetch_en2, out_ready2;
  logic [31:0] imem_addr2, imem_rd_instr2, out_instr2, out_pc2;
  logic        out_valid2, fetch_err2;
  logic [3:0]  fifo_count2;

  int checks = 0;
  int errors = 0;
  logic [31:0] expq[$];
  logic [31:0] expq2[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
  endfunction

  assign imem_rd_instr  = imem_f(imem_addr);
  assign imem_rd_instr2 = imem_f(imem_addr2);

  instr_fetch_ctrl #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .imem_addr(imem_addr),
    .imem_rd_instr(imem_rd_instr), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .fifo_count(fifo_count),
    .fetch_err(fetch_err)
  );

  instr_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
    .clk(clk), .reset(reset), .fetch_en(fetch_en2), .imem_addr(imem_addr2),
    .imem_rd_instr(imem_rd_instr2), .redirect_valid(1'b0),
    .redirect_pc(32'h0), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_instr(out_instr2), .out_pc(out_pc2), .fifo_count(fifo_count2),
    .fetch_err(fetch_err2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; consumes expq in order, then deasserts out_ready.
  task automatic drain(input int budget, input bit strict);
    int n = 0;
    out_ready = 1'b1;
    while (expq.size() != 0 && n < budget) begin
      if (strict) chk("valid_steady", {31'b0, out_valid}, 32'd1);
      if (out_valid) begin
        chk("out_pc", out_pc, expq[0]);
        chk("out_instr", out_instr, imem_f(expq[0]));
        void'(expq.pop_front());
        if (expq.size() == 0) break;
      end
      @(negedge clk);
      n++;
    end
    if (expq.size() != 0) chk("drain_timeout", expq.size(), 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int n;
    reset = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    out_ready = 1'b0; fetch_en2 = 1'b0; out_ready2 = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_count", {28'b0, fifo_count}, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_err", {31'b0, fetch_err}, 32'd0);

    // 1: streaming, two-cycle start latency, 71 words
    reset = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("lat_edge1_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk("lat_edge2_valid", {31'b0, out_valid}, 32'd1);
    for (int unsigned i = 0; i < 71; i++) expq.push_back(32'(i * 4));
    drain(120, 1'b1);
    chk("stream_err", {31'b0, fetch_err}, 32'd0);

    // 2: backpressure saturates FIFO and holds fetch PC
    pulse_reset();
    fetch_en = 1'b1; out_ready = 1'b0;
    repeat (6) @(negedge clk);
    chk("bp_count", {28'b0, fifo_count}, 32'd2);
    chk("bp_addr", imem_addr, 32'h8);
    chk("bp_head_pc", out_pc, 32'h0);
    chk("bp_valid", {31'b0, out_valid}, 32'd1);
    for (int unsigned i = 0; i < 9; i++) expq.push_back(32'(i * 4));
    drain(60, 1'b0);

    // 3: aligned redirect with full FIFO and out_ready=1
    repeat (4) @(negedge clk);
    chk("pre_redir_count", {28'b0, fifo_count}, 32'd2);
    redirect_valid = 1'b1; redirect_pc = 32'h40; out_ready = 1'b1;
    expq.delete();
    @(negedge clk);
    redirect_valid = 1'b0; out_ready = 1'b0;
    chk("redir_valid", {31'b0, out_valid}, 32'd0);
    chk("redir_count", {28'b0, fifo_count}, 32'd0);
    chk("redir_addr", imem_addr, 32'h40);
    expq.push_back(32'h40); expq.push_back(32'h44); expq.push_back(32'h48);
    drain(20, 1'b0);

    // 4: misaligned redirect is sticky until reset
    pulse_reset();
    fetch_en = 1'b1; out_ready = 1'b0;
    repeat (6) @(negedge clk);
    chk("err_pre_addr", imem_addr, 32'h8);
    redirect_valid = 1'b1; redirect_pc = 32'h42; out_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("err_flag", {31'b0, fetch_err}, 32'd1);
    chk("err_valid", {31'b0, out_valid}, 32'd0);
    chk("err_count", {28'b0, fifo_count}, 32'd0);
    chk("err_addr", imem_addr, 32'h8);
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("err_valid_later", {31'b0, out_valid}, 32'd0);
    chk("err_addr_frozen", imem_addr, 32'h8);
    chk("err_flag_sticky", {31'b0, fetch_err}, 32'd1);
    reset = 1'b1; fetch_en = 1'b0; out_ready = 1'b0;
    #1;
    chk("err_cleared", {31'b0, fetch_err}, 32'd0);
    chk("err_rst_addr", imem_addr, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // 5: PC wraps through 2^32 without a bubble
    pulse_reset();
    fetch_en2 = 1'b1; out_ready2 = 1'b1;
    expq2.push_back(32'hFFFF_FFF8); expq2.push_back(32'hFFFF_FFFC);
    expq2.push_back(32'h0000_0000); expq2.push_back(32'h0000_0004);
    seen = 1'b0; n = 0;
    while (expq2.size() != 0 && n < 20) begin
      if (seen) chk("wrap_steady", {31'b0, out_valid2}, 32'd1);
      if (out_valid2) begin
        seen = 1'b1;
        chk("wrap_pc", out_pc2, expq2[0]);
        chk("wrap_instr", out_instr2, imem_f(expq2[0]));
        void'(expq2.pop_front());
      end
      @(negedge clk);
      n++;
    end
    if (expq2.size() != 0) chk("wrap_timeout", expq2.size(), 32'd0);
    fetch_en2 = 1'b0; out_ready2 = 1'b0;

    // 6: asynchronous reset between edges mid-stream
    pulse_reset();
    fetch_en = 1'b1; out_ready = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_pre_count", {28'b0, fifo_count}, 32'd2);
    reset = 1'b1;
    #1;
    chk("mid_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_count", {28'b0, fifo_count}, 32'd0);
    chk("mid_instr", out_instr, 32'd0);
    chk("mid_pc", out_pc, 32'd0);
    chk("mid_addr", imem_addr, 32'h0);
    @(negedge clk);
    reset = 1'b0; fetch_en = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
